// File: rtl/noc_pkg.sv
// Shared NoC types: flit-type codes, requester FSM states and the FIFO entry payload.
`ifndef NOC_DEFINE_SV
`include "define.sv"
`endif

package noc_pkg;

  localparam int unsigned DATA_W = `DATAW + 1;
  localparam int unsigned VCH_W  = `VCHW + 1;
  localparam int unsigned PORT_W = `PORTW + 1;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } cbreq_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [VCH_W-1:0]  vch;
    logic [PORT_W-1:0] port;
  } flit_entry_t;

  localparam int unsigned ENTRY_W = $bits(flit_entry_t);

  function automatic logic [1:0] flit_type(input logic [`DATAW:0] data);
    return data[`DATAW:`DATAW-1];
  endfunction

endpackage

// File: rtl/define.sv
// Global NoC field widths; each macro is (field width - 1).
`ifndef NOC_DEFINE_SV
`define NOC_DEFINE_SV
`define DATAW 34
`define VCHW 1
`define PORTW 2
`endif

// File: rtl/flit_fifo.sv
// Synchronous FIFO, DEPTH a power of two >= 2; front entry is visible the cycle after its write.
module flit_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  // No write-through: a full FIFO refuses the push even when popping.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cb_req_unit.sv
// Crossbar requester: buffers input flits, requests the routed output port and
// streams the granted packet; malformed or misrouted traffic is discarded.
module cb_req_unit
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NPORTS = 5
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [`DATAW:0]   in_data,
  input  logic              in_valid,
  input  logic [`VCHW:0]    in_vch,
  input  logic [`PORTW:0]   in_port,
  output logic              in_ready,
  output logic              req,
  output logic [`PORTW:0]   port,
  input  logic              grt,
  output logic [`DATAW:0]   idata,
  output logic              ivalid,
  output logic [`VCHW:0]    ivch,
  output logic              drop_err,
  output logic              grt_lost
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cbreq_state_t      state_q;
  cbreq_state_t      state_d;
  flit_entry_t       wr_entry;
  flit_entry_t       front;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_count;
  logic [1:0]        front_type;
  logic              front_is_head;
  logic              front_is_tail;
  logic              front_legal;
  logic              pop_c;
  logic              drop_c;
  logic              latch_c;
  logic              ivalid_c;
  logic [`PORTW:0]   port_reg;
  logic [`VCHW:0]    vch_reg;
  logic              req_q;
  logic              head_sent_q;
  logic              drop_err_q;
  logic              grt_lost_q;

  assign wr_entry = '{data: in_data, vch: in_vch, port: in_port};

  flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (in_valid),
    .pop   (pop_c),
    .wdata (wr_entry),
    .rdata (front),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_count  = ^fifo_count;
  assign front_type    = flit_type(front.data);
  assign front_is_head = (front_type == FT_HEAD) || (front_type == FT_SINGLE);
  assign front_is_tail = (front_type == FT_TAIL) || (front_type == FT_SINGLE);
  assign front_legal   = (32'(front.port) < NPORTS);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, FIFO pop and crossbar transfer decode.
  always_comb begin
    state_d  = state_q;
    pop_c    = 1'b0;
    drop_c   = 1'b0;
    latch_c  = 1'b0;
    ivalid_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (front_is_head && front_legal) begin
            latch_c = 1'b1;
            state_d = ACTIVE;
          end else begin
            pop_c  = 1'b1;
            drop_c = 1'b1;
            if (front_type == FT_HEAD) state_d = DROP;
          end
        end
      end
      ACTIVE: begin
        ivalid_c = grt & ~fifo_empty;
        pop_c    = ivalid_c;
        if (ivalid_c && front_is_tail) state_d = IDLE;
      end
      DROP: begin
        if (!fifo_empty) begin
          pop_c = 1'b1;
          if (front_type == FT_TAIL) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route latch, request and status flags.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      port_reg    <= '0;
      vch_reg     <= '0;
      req_q       <= 1'b0;
      head_sent_q <= 1'b0;
      drop_err_q  <= 1'b0;
      grt_lost_q  <= 1'b0;
    end else begin
      if (latch_c) begin
        port_reg <= front.port;
        vch_reg  <= front.vch;
      end
      req_q      <= (state_d == ACTIVE);
      drop_err_q <= drop_c;
      if (state_d != ACTIVE)                   head_sent_q <= 1'b0;
      else if (state_q == ACTIVE && pop_c)     head_sent_q <= 1'b1;
      if (state_q == ACTIVE && head_sent_q && !grt) grt_lost_q <= 1'b1;
    end
  end

  assign in_ready = ~fifo_full;
  assign req      = req_q;
  assign port     = port_reg;
  assign ivalid   = ivalid_c;
  assign idata    = (state_q == ACTIVE) ? front.data : '0;
  assign ivch     = (state_q == ACTIVE) ? vch_reg : '0;
  assign drop_err = drop_err_q;
  assign grt_lost = grt_lost_q;

endmodule
